// File: rtl/mont_redc_seq_if.sv
// Valid/ready handshake bundle for the Montgomery reducer: product T in, reduced residue out.
interface mont_redc_seq_if #(
  parameter int WIDTH = 255
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] t_in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   res_out;
  logic               busy;

  modport master (
    output in_valid, t_in, out_ready,
    input  in_ready, out_valid, res_out, busy
  );

  modport slave (
    input  in_valid, t_in, out_ready,
    output in_ready, out_valid, res_out, busy
  );
endinterface

// File: rtl/mont_redc_seq.sv
// Digit-serial Montgomery reduction: res = T * 2^-WIDTH mod MODULUS, one DIGIT-bit quotient per cycle.
// Optional macro MONT_REDC_PERFCNT_EN adds a 32-bit completed-result counter port op_count.
module mont_redc_seq #(
  parameter int               WIDTH   = 255,
  parameter int               DIGIT   = 17,
  parameter logic [WIDTH-1:0] MODULUS = {{(WIDTH-8){1'b1}}, 8'hED}
) (
  input  logic               clk,
  input  logic               rst_n,
  mont_redc_seq_if.slave     bus
`ifdef MONT_REDC_PERFCNT_EN
  ,
  output logic [31:0]        op_count
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int AW   = 2*WIDTH + 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("mont_redc_seq: WIDTH must be divisible by DIGIT");
  end
  if (MODULUS[0] != 1'b1) begin : g_even_modulus
    $error("mont_redc_seq: MODULUS must be odd");
  end

  // Newton iteration doubles the number of correct low bits of p^-1 each pass.
  function automatic logic [DIGIT-1:0] calc_nprime(input logic [DIGIT-1:0] p_lo);
    logic [DIGIT-1:0] inv;
    logic [DIGIT-1:0] two;
    inv = DIGIT'(1);
    two = DIGIT'(2);
    for (int b = 1; b < DIGIT; b = b * 2) begin
      inv = inv * (two - p_lo * inv);
    end
    return -inv;
  endfunction

  localparam logic [DIGIT-1:0] NPRIME = calc_nprime(MODULUS[DIGIT-1:0]);

  function automatic logic [WIDTH-1:0] final_reduce(input logic [WIDTH:0] a);
    if (a >= {1'b0, MODULUS}) return a[WIDTH-1:0] - MODULUS;
    else                      return a[WIDTH-1:0];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINAL, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [AW-1:0]           r_acc;
  logic [CW-1:0]           r_cnt;
  logic [WIDTH-1:0]        r_res;
  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_busy;
  logic [DIGIT-1:0]        w_m;
  logic [WIDTH+DIGIT-1:0]  w_mp;
  logic [AW-1:0]           w_sum;
  logic                    w_last;

  assign w_last = (r_cnt == CW'(NDIG-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = S_ITER;
      end
      S_ITER: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_FINAL;
      end
      S_FINAL: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.res_out   = r_res;

  // Quotient digit makes the low DIGIT bits of the sum vanish; T < p*R keeps the sum within AW bits.
  assign w_m   = r_acc[DIGIT-1:0] * NPRIME;
  assign w_mp  = {{WIDTH{1'b0}}, w_m} * {{DIGIT{1'b0}}, MODULUS};
  assign w_sum = r_acc + {{(AW-WIDTH-DIGIT){1'b0}}, w_mp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_res <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_acc <= {1'b0, bus.t_in};
            r_cnt <= '0;
          end
        end
        S_ITER: begin
          r_acc <= w_sum >> DIGIT;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FINAL: r_res <= final_reduce(r_acc[WIDTH:0]);
        default: ;
      endcase
    end
  end

`ifdef MONT_REDC_PERFCNT_EN
  logic [31:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_op_count <= '0;
    else if (w_out_valid && bus.out_ready)    r_op_count <= r_op_count + 32'd1;
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: doc/mont_redc_seq.md
Name: mont_redc_seq

Overview:
- Sequential Montgomery reduction (REDC). Consumes the 510-bit integer product from the 255x255 multiplier and returns T*R^-1 mod MODULUS, where R = 2^WIDTH.
- Digit-serial: one DIGIT-bit quotient digit per cycle, then a single conditional final subtraction.
- Sits directly downstream of the multiplier in the field-arithmetic datapath. Valid/ready on both sides.

Parameters:
- WIDTH, 255, operand/modulus width in bits; R = 2^WIDTH.
- DIGIT, 17, bits retired per iteration; WIDTH must be divisible by DIGIT (elaboration error otherwise).
- MODULUS, 2^255-19, odd modulus p, WIDTH bits.
- NDIG (localparam), WIDTH/DIGIT = 15, number of iterations.
- NPRIME (localparam), (-MODULUS^-1) mod 2^DIGIT, computed at elaboration by a constant function (Newton iteration).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  T is valid.
- in_ready  out  1  block can accept T.
- t_in  in  2*WIDTH  product T; caller guarantees T < MODULUS*R.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- res_out  out  WIDTH  T*R^-1 mod MODULUS, fully reduced to [0, MODULUS-1].
- busy  out  1  high in ITER or FINAL.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE.
  - in_ready=1, out_valid=0, busy=0, res_out=0, accumulator=0, iteration counter=0.
  - Reset takes effect mid-operation: any in-flight reduction is discarded and no output is produced for it.
- FSM states: IDLE, ITER, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: acc <= {1'b0, t_in} (acc is 2*WIDTH+1 bits), cnt <= 0, go to ITER.
- ITER (in_ready=0, busy=1), each cycle:
  - m = (acc[DIGIT-1:0]*NPRIME) mod 2^DIGIT.
  - acc <= (acc + m*MODULUS) >> DIGIT. The low DIGIT bits of the sum are zero by construction.
  - cnt++. When cnt reaches NDIG-1, go to FINAL.
  - Intermediate sums need 2*WIDTH+1 bits; no truncation is permitted before the shift.
- FINAL (busy=1):
  - acc < 2*MODULUS is guaranteed.
  - res_out <= (acc >= MODULUS) ? acc - MODULUS : acc, truncated to WIDTH bits.
  - out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1. res_out is held stable while out_ready=0.
  - On out_ready: out_valid <= 0, go to IDLE.
  - res_out retains its last value after the handshake.
- Latency: input handshake at cycle 0 → ITER in cycles 1..15 → FINAL at cycle 16 → out_valid high from cycle 17. Minimum 18 cycles between accepted inputs.
- in_valid while not in IDLE: ignored (in_ready=0). t_in is sampled only on the handshake.
- in_valid and out_ready both high in DONE: only the output handshake completes that cycle. The next input is accepted in IDLE on the following cycle.
- T = 0 yields 0. T >= MODULUS*R is out of contract; the result is unspecified, but the FSM must still complete and return to IDLE.

Optional Feature:
- Macro: MONT_REDC_PERFCNT_EN.
- Defined: adds output port op_count [31:0].
  - Reset to 0 by rst_n.
  - Increments by 1 on each completed output handshake (out_valid&&out_ready).
  - Wraps from 2^32-1 to 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset release; t_in=5*2^255 with in_valid for one cycle → in_ready drops at cycle 1; out_valid rises at cycle 17 with res_out=5; busy high in cycles 1..16.
- t_in=2^255 → res_out=1. t_in=MODULUS → res_out=0. t_in=0 → res_out=0.
- t_in=(MODULUS-1)^2 (multiplier output for A=B=p-1) → res_out = (p-1)^2*2^-255 mod p, matched against the reference model; exercises the final-subtract path.
- Backpressure: out_ready low for 10 cycles after out_valid → res_out stable, in_ready=0, a new in_valid is ignored. out_ready high → out_valid low next cycle, in_ready high.
- rst_n asserted low asynchronously during ITER cycle 7 → out_valid=0, in_ready=1 immediately. After release, t_in=3*2^255 → res_out=3 at the standard latency.
- With MONT_REDC_PERFCNT_EN: 4 back-to-back reductions → op_count=4. Force the counter to 2^32-1, complete one reduction → op_count=0.
